// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, extended sub-ops and state encoding for control_unit_p
package cu_pkg;
  typedef enum logic {S_FETCH = 1'b0, S_EXECUTE = 1'b1} state_t;

  localparam logic [3:0] OP_NOPX     = 4'h0;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_JMP      = 4'h3;
  localparam logic [3:0] OP_BEQ      = 4'h4;
  localparam logic [3:0] OP_BC       = 4'h5;
  localparam logic [3:0] OP_IN       = 4'h6;
  localparam logic [3:0] OP_OUT      = 4'h7;
  localparam logic [3:0] OP_ALU_BASE = 4'h8;

  localparam logic [3:0] X_NOP  = 4'h0;
  localparam logic [3:0] X_RET  = 4'h1;
  localparam logic [3:0] X_CALL = 4'h2;
endpackage

// File: rtl/cu_return_stack.sv
// rtl/cu_return_stack.sv - LIFO of return addresses with full/empty status
module cu_return_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem [STACK_DEPTH];
  logic [AW:0]  count;
  logic [AW:0]  top_idx;

  assign full    = (count == (AW+1)'(STACK_DEPTH));
  assign empty   = (count == '0);
  assign top_idx = count - ONE;
  assign top     = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[count[AW-1:0]] <= din;
      count <= count + ONE;
    end else if (pop && !empty) begin
      count <= count - ONE;
    end
  end
endmodule

// File: rtl/control_unit_p.sv
// rtl/control_unit_p.sv - two-phase fetch/execute sequencer with flags, GPIO ports and return stack
module control_unit_p
  import cu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_PORTS = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      clk_valid,
  input  logic [15:0]               instruction,
  input  logic [11:0]               pc,
  input  logic [DATA_W-1:0]         sram_read_data,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      equal,
  input  logic                      carry_out,
  input  logic [DATA_W-1:0]         in_gpio,
  input  logic                      bootstrapping,
  output logic [2:0]                alu_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic                      sram_write_en,
  output logic [7:0]                sram_addr,
  output logic [DATA_W-1:0]         sram_write_data,
  output logic                      pc_load,
  output logic [11:0]               pc_next,
  output logic                      pc_inc,
  output logic [N_PORTS*DATA_W-1:0] out_gpio,
  output logic [1:0]                flags,
  output logic                      stack_err,
  output logic                      state
);
  state_t            st;
  logic [3:0]        op_f, rd_f, ra_f, rb_f;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] in_smp;
  logic              stk_full, stk_empty;
  logic [11:0]       stk_top;
  logic              is_x, do_call, do_ret;

  // Stack strobes mirror the FSM's EXECUTE decision so both update on the same edge.
  assign is_x    = clk_valid && (st == S_EXECUTE) && (op_f == OP_NOPX);
  assign do_call = is_x && (rd_f == X_CALL) && !stk_full;
  assign do_ret  = is_x && (rd_f == X_RET) && !stk_empty;

  cu_return_stack #(.STACK_DEPTH(STACK_DEPTH), .W(12)) u_stack (
    .clk   (clk),
    .arst  (arst),
    .push  (do_call),
    .pop   (do_ret),
    .din   (pc),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top)
  );

  assign state  = st;
  assign pc_inc = (st == S_FETCH);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      st              <= S_FETCH;
      {op_f, rd_f, ra_f, rb_f} <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      in_smp          <= '0;
      out_gpio        <= '0;
      flags           <= '0;
      stack_err       <= 1'b0;
      pc_load         <= 1'b0;
      pc_next         <= '0;
      sram_write_en   <= 1'b0;
      sram_write_data <= '0;
      sram_addr       <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_opcode      <= '0;
    end else if (clk_valid) begin
      case (st)
        S_FETCH: begin
          {op_f, rd_f, ra_f, rb_f} <= instruction;
          alu_a           <= regs[instruction[7:4]];
          alu_b           <= regs[instruction[3:0]];
          alu_opcode      <= instruction[14:12];
          sram_addr       <= instruction[7:0];
          sram_write_data <= regs[instruction[11:8]];
          in_smp          <= in_gpio;
          // Strobes raised by the previous EXECUTE last exactly one cycle.
          pc_load         <= 1'b0;
          sram_write_en   <= 1'b0;
          st              <= S_EXECUTE;
        end
        S_EXECUTE: begin
          pc_load       <= 1'b0;
          sram_write_en <= 1'b0;
          st            <= S_FETCH;
          if (op_f >= OP_ALU_BASE) begin
            regs[rd_f] <= alu_result;
            flags      <= {carry_out, equal};
          end else begin
            case (op_f)
              OP_NOPX: begin
                case (rd_f)
                  X_NOP: ;
                  X_RET: begin
                    if (stk_empty) stack_err <= 1'b1;
                    else begin
                      pc_next <= stk_top;
                      pc_load <= 1'b1;
                    end
                  end
                  X_CALL: begin
                    if (stk_full) stack_err <= 1'b1;
                    else begin
                      pc_next <= {pc[11:8], ra_f, rb_f};
                      pc_load <= 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
              OP_LOAD:  regs[rd_f] <= sram_read_data;
              OP_STORE: sram_write_en <= 1'b1;
              OP_JMP: begin
                pc_next <= {rd_f, ra_f, rb_f};
                pc_load <= 1'b1;
              end
              OP_BEQ: if (flags[0]) begin
                pc_next <= {rd_f, ra_f, rb_f};
                pc_load <= 1'b1;
              end
              OP_BC: if (flags[1]) begin
                pc_next <= {rd_f, ra_f, rb_f};
                pc_load <= 1'b1;
              end
              OP_IN: regs[rd_f] <= bootstrapping ? DATA_W'({ra_f, rb_f}) : in_smp;
              OP_OUT: begin
                for (int k = 0; k < N_PORTS; k++)
                  if (rb_f == 4'(k)) out_gpio[k*DATA_W +: DATA_W] <= regs[rd_f];
              end
              default: ;
            endcase
          end
        end
        default: st <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit_p.sv
// tb/tb_control_unit_p.sv - scoreboard bench for control_unit_p with directed instruction vectors
module tb_control_unit_p;
  logic        clk = 1'b0;
  logic        arst, clk_valid, equal, carry_out, bootstrapping;
  logic [15:0] instruction;
  logic [11:0] pc;
  logic [7:0]  sram_read_data, alu_result, in_gpio;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, sram_addr, sram_write_data;
  logic        sram_write_en, pc_load, pc_inc, stack_err, state;
  logic [11:0] pc_next;
  logic [15:0] out_gpio;
  logic [1:0]  flags;

  control_unit_p #(.DATA_W(8), .N_PORTS(2), .STACK_DEPTH(4)) dut (
    .clk(clk), .arst(arst), .clk_valid(clk_valid), .instruction(instruction), .pc(pc),
    .sram_read_data(sram_read_data), .alu_result(alu_result), .equal(equal),
    .carry_out(carry_out), .in_gpio(in_gpio), .bootstrapping(bootstrapping),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .sram_write_en(sram_write_en),
    .sram_addr(sram_addr), .sram_write_data(sram_write_data), .pc_load(pc_load),
    .pc_next(pc_next), .pc_inc(pc_inc), .out_gpio(out_gpio), .flags(flags),
    .stack_err(stack_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pl;
    logic [11:0] pn;
    logic        we;
    logic [15:0] gpio;
    logic [1:0]  flg;
    logic        err;
    logic        chk_sram;
    logic [7:0]  addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic last_state = 1'b0;
  logic last_rst = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic pl, input logic [11:0] pn, input logic we,
                              input logic [15:0] g, input logic [1:0] f, input logic er);
    exp_t e;
    e.rst = 1'b0; e.pl = pl; e.pn = pn; e.we = we; e.gpio = g; e.flg = f; e.err = er;
    e.chk_sram = 1'b0; e.addr = '0; e.wdata = '0;
    return e;
  endfunction

  function automatic exp_t mk_rst();
    exp_t e;
    e = mk(1'b0, 12'h000, 1'b0, 16'h0000, 2'b00, 1'b0);
    e.rst = 1'b1; e.chk_sram = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] ins(input logic [3:0] o, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b);
    return {o, d, a, b};
  endfunction

  task automatic compare(input logic is_rst);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event", 32'(is_rst) + 32'h100, 32'h0);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", 32'(is_rst), 32'(e.rst));
    chk("state", 32'(state), 32'h0);
    chk("pc_load", 32'(pc_load), 32'(e.pl));
    chk("sram_write_en", 32'(sram_write_en), 32'(e.we));
    chk("out_gpio", 32'(out_gpio), 32'(e.gpio));
    chk("flags", 32'(flags), 32'(e.flg));
    chk("stack_err", 32'(stack_err), 32'(e.err));
    if (e.pl || e.rst) chk("pc_next", 32'(pc_next), 32'(e.pn));
    if (e.chk_sram) begin
      chk("sram_addr", 32'(sram_addr), 32'(e.addr));
      chk("sram_write_data", 32'(sram_write_data), 32'(e.wdata));
    end
    if (e.rst) begin
      chk("pc_inc", 32'(pc_inc), 32'h1);
      chk("alu_ops", {13'h0, alu_opcode, alu_a, alu_b}, 32'h0);
    end
  endtask

  // Monitor: a reset assertion or an EXECUTE->FETCH transition is one observable event.
  always @(negedge clk) begin
    if (arst) begin
      if (!last_rst) compare(1'b1);
      last_state = 1'b0;
    end else begin
      if (last_state && !state) compare(1'b0);
      last_state = state;
    end
    last_rst = arst;
  end

  task automatic issue(input logic [15:0] i, input logic [11:0] pcv, input exp_t e);
    instruction = i;
    pc = pcv;
    sb.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    arst = 1'b1; clk_valid = 1'b1; instruction = '0; pc = '0; sram_read_data = '0;
    alu_result = '0; equal = 1'b0; carry_out = 1'b0; in_gpio = '0; bootstrapping = 1'b0;
    sb.push_back(mk_rst());
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;

    // IN immediate, OUT to an existing and a non-existent port, IN from the pad
    bootstrapping = 1'b1;
    issue(ins(4'h6, 4'h1, 4'h5, 4'hA), 12'h001, mk(0, 12'h0, 0, 16'h0000, 2'b00, 0));
    bootstrapping = 1'b0;
    issue(ins(4'h7, 4'h1, 4'h0, 4'h1), 12'h002, mk(0, 12'h0, 0, 16'h5A00, 2'b00, 0));
    issue(ins(4'h7, 4'h1, 4'h0, 4'h3), 12'h003, mk(0, 12'h0, 0, 16'h5A00, 2'b00, 0));
    in_gpio = 8'h3C;
    issue(ins(4'h6, 4'h3, 4'h0, 4'h0), 12'h004, mk(0, 12'h0, 0, 16'h5A00, 2'b00, 0));
    in_gpio = 8'h00;
    issue(ins(4'h7, 4'h3, 4'h0, 4'h0), 12'h005, mk(0, 12'h0, 0, 16'h5A3C, 2'b00, 0));
    e = mk(0, 12'h0, 1, 16'h5A3C, 2'b00, 0);
    e.chk_sram = 1'b1; e.addr = 8'h7E; e.wdata = 8'h3C;
    issue(ins(4'h2, 4'h3, 4'h7, 4'hE), 12'h006, e);

    // Latched Z set, then live equal/carry ignored by NOP and branches
    alu_result = 8'h11; equal = 1'b1; carry_out = 1'b0;
    issue(ins(4'h8, 4'h4, 4'h1, 4'h3), 12'h007, mk(0, 12'h0, 0, 16'h5A3C, 2'b01, 0));
    equal = 1'b0; carry_out = 1'b1;
    issue(ins(4'h0, 4'h0, 4'h0, 4'h0), 12'h008, mk(0, 12'h0, 0, 16'h5A3C, 2'b01, 0));
    issue(ins(4'h4, 4'h1, 4'h2, 4'h3), 12'h009, mk(1, 12'h123, 0, 16'h5A3C, 2'b01, 0));
    issue(ins(4'h5, 4'h4, 4'h5, 4'h6), 12'h124, mk(0, 12'h0, 0, 16'h5A3C, 2'b01, 0));
    issue(ins(4'h7, 4'h4, 4'h0, 4'h0), 12'h125, mk(0, 12'h0, 0, 16'h5A11, 2'b01, 0));

    // Latched C set, Z clear
    alu_result = 8'h22; equal = 1'b0; carry_out = 1'b1;
    issue(ins(4'h9, 4'h5, 4'h0, 4'h0), 12'h126, mk(0, 12'h0, 0, 16'h5A11, 2'b10, 0));
    equal = 1'b1; carry_out = 1'b0;
    issue(ins(4'h0, 4'h0, 4'h0, 4'h0), 12'h127, mk(0, 12'h0, 0, 16'h5A11, 2'b10, 0));
    issue(ins(4'h4, 4'h1, 4'h2, 4'h3), 12'h128, mk(0, 12'h0, 0, 16'h5A11, 2'b10, 0));
    issue(ins(4'h5, 4'h3, 4'hA, 4'hB), 12'h129, mk(1, 12'h3AB, 0, 16'h5A11, 2'b10, 0));
    equal = 1'b0;
    issue(ins(4'h3, 4'h7, 4'h8, 4'h9), 12'h3AC, mk(1, 12'h789, 0, 16'h5A11, 2'b10, 0));

    // CALL / RET pair
    issue(ins(4'h0, 4'h2, 4'h4, 4'h5), 12'h310, mk(1, 12'h345, 0, 16'h5A11, 2'b10, 0));
    issue(ins(4'h0, 4'h1, 4'h0, 4'h0), 12'h346, mk(1, 12'h310, 0, 16'h5A11, 2'b10, 0));

    // Overflow on the fifth CALL, underflow on the fifth RET
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) e = mk(1, 12'(k * 256 + 16 + k), 0, 16'h5A11, 2'b10, 0);
      else       e = mk(0, 12'h0, 0, 16'h5A11, 2'b10, 1);
      issue(ins(4'h0, 4'h2, 4'h1, 4'(k)), 12'(k * 256), e);
    end
    for (int k = 4; k >= 0; k--) begin
      if (k > 0) e = mk(1, 12'(k * 256), 0, 16'h5A11, 2'b10, 1);
      else       e = mk(0, 12'h0, 0, 16'h5A11, 2'b10, 1);
      issue(ins(4'h0, 4'h1, 4'h0, 4'h0), 12'h600, e);
    end

    // LOAD frozen for three cycles in EXECUTE; stale read data must not land
    instruction = ins(4'h1, 4'h2, 4'h0, 4'h0);
    pc = 12'h700;
    sram_read_data = 8'hEE;
    sb.push_back(mk(0, 12'h0, 0, 16'h5A11, 2'b10, 1));
    @(posedge clk); #1;
    clk_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("freeze_state", 32'(state), 32'h1);
      chk("freeze_pc_inc", 32'(pc_inc), 32'h0);
    end
    sram_read_data = 8'hC3;
    clk_valid = 1'b1;
    @(posedge clk); #1;
    sram_read_data = 8'h00;
    issue(ins(4'h7, 4'h2, 4'h0, 4'h0), 12'h701, mk(0, 12'h0, 0, 16'h5AC3, 2'b10, 1));

    // Reset during EXECUTE of a STORE, then confirm the register file was cleared
    instruction = ins(4'h2, 4'h1, 4'h0, 4'h0);
    sb.push_back(mk_rst());
    @(posedge clk); #1;
    arst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst = 1'b0;
    issue(ins(4'h7, 4'h1, 4'h0, 4'h1), 12'h000, mk(0, 12'h0, 0, 16'h0000, 2'b00, 0));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
